input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Front-end stage ahead of the vending FSM. Synchronises and debounces the raw L/R/C
//  push-buttons and the four coin switches, then emits clean single-cycle pulses.
//  Coin pulses are also encoded into one coin_valid/coin_value strobe, so the FSM adds
//  exactly one denomination per physical insertion.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles before a level is accepted (>=1; 10 ms @ 50 MHz)
//  CNT_W            20      debounce counter width; must hold DEBOUNCE_CYCLES-1
//  COIN0_VAL        1       value for switch[0]
//  COIN1_VAL        5       value for switch[1]
//  COIN2_VAL        10      value for switch[2]
//  COIN3_VAL        20      value for switch[3]
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  synchronous reset, active-low
//  L_button    in   1  raw left button, active-high, asynchronous
//  R_button    in   1  raw right button, active-high, asynchronous
//  C_button    in   1  raw confirm button, active-high, asynchronous
//  switch      in   4  raw coin switches, active-high, asynchronous
//  L_pulse     out  1  one-cycle pulse per debounced L press
//  R_pulse     out  1  one-cycle pulse per debounced R press
//  C_pulse     out  1  one-cycle pulse per debounced C press
//  coin_valid  out  1  one-cycle strobe: one coin accepted
//  coin_value  out  5  denomination for coin_valid; 0 when coin_valid=0
//  coin_drop   out  1  one-cycle pulse: >1 coin edge in the same cycle, lower ones discarded
// BEHAVIOUR
//  - 7 identical channels: {switch[3:0], C, R, L}. Per channel: 2-FF synchroniser
//    (s1, s2), CNT_W counter, stable level, stable_d delay reg.
//  - Reset (rst=0 at a clk edge): s1, s2, counters, stable, stable_d and all outputs go to 0.
//    Reset wins over every other event. A channel held high through reset is seen as a
//    new press after release: its pulse fires D+2 edges after the first non-reset edge.
//  - Debounce: if s2==stable, cnt<=0. Otherwise, if cnt==DEBOUNCE_CYCLES-1, then
//    stable<=s2 and cnt<=0; else cnt<=cnt+1. Any bounce back to stable level clears cnt.
//  - Latency: raw input first sampled high at edge k. Then s2=1 after k+1 and stable=1
//    after k+1+D (D=DEBOUNCE_CYCLES). The pulse is high for exactly the one cycle after
//    edge k+D+2.
//  - rise = stable & ~stable_d, registered into the pulse outputs. stable_d<=stable on every edge.
//    Release (1->0) is debounced the same way but produces no pulse.
//    Holding an input high gives exactly one pulse; there is no auto-repeat.
//  - Buttons are independent. Simultaneous L and R rises both pulse; the FSM arbitrates.
//  - Coin encode, registered on the same edge as the pulses, from the coin rise vector:
//    priority switch[3] > [2] > [1] > [0].
//    coin_valid=1 and coin_value=the highest risen coin's value.
//    coin_drop=1 iff two or more coin rises occur in that cycle.
//    No coin rises: coin_valid=0, coin_value=0, coin_drop=0.
//  - coin_value is 5 bits unsigned; COINx_VAL must be <=31. There is no internal accumulation.
//  - Outputs are fully registered; there are no combinational paths from inputs to outputs.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Reset with all inputs 0, hold 10 cycles.
//     -> all outputs 0. rst=0 mid-count also clears the counter, with no pulse.
//  2. L_button 0->1 clean at edge k, held 20 cycles.
//     -> L_pulse high only in the cycle after edge k+6; R_pulse and C_pulse stay 0.
//  3. C_button bounces 1,0,1,0 (1 cycle each), then holds high.
//     -> no pulse during the bounce; one C_pulse 6 edges after the final rise.
//     A 3-cycle glitch gives no pulse.
//  4. switch[2] clean press, held 30 cycles.
//     -> one cycle of coin_valid=1, coin_value=10, coin_drop=0. Release gives no strobe.
//  5. switch[0] and switch[3] rise on the same edge.
//     -> coin_valid=1, coin_value=20, coin_drop=1, all for one cycle.
//  6. L_button held high across reset, then rst released at edge r.
//     -> L_pulse in the cycle after edge r+6.

Source files
------------

// File: rtl/input_conditioner.sv
// Synchronises and debounces the L/R/C buttons and four coin switches, then emits
// registered single-cycle press pulses plus a priority-encoded coin strobe.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int COIN0_VAL       = 1,
  parameter int COIN1_VAL       = 5,
  parameter int COIN2_VAL       = 10,
  parameter int COIN3_VAL       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       L_button,
  input  logic       R_button,
  input  logic       C_button,
  input  logic [3:0] switch,
  output logic       L_pulse,
  output logic       R_pulse,
  output logic       C_pulse,
  output logic       coin_valid,
  output logic [4:0] coin_value,
  output logic       coin_drop
);

  localparam int NCH = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] VAL0 = 5'(COIN0_VAL);
  localparam logic [4:0] VAL1 = 5'(COIN1_VAL);
  localparam logic [4:0] VAL2 = 5'(COIN2_VAL);
  localparam logic [4:0] VAL3 = 5'(COIN3_VAL);

  logic [NCH-1:0]   rawIn;
  logic [NCH-1:0]   s1_q, s2_q, stable_q, stableDly_q;
  logic [NCH-1:0]   stable_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   rise;
  logic [3:0]       coinRise;
  logic             coinValid_d, coinDrop_d;
  logic [4:0]       coinValue_d;

  assign rawIn    = {switch, C_button, R_button, L_button};
  assign rise     = stable_q & ~stableDly_q;
  assign coinRise = rise[6:3];

  // Any sample that disagrees with the accepted level must persist for the full window.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      stable_d[ch] = stable_q[ch];
      cnt_d[ch]    = '0;
      if (s2_q[ch] != stable_q[ch]) begin
        if (cnt_q[ch] == CNT_MAX) begin
          stable_d[ch] = s2_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    coinValid_d = |coinRise;
    coinDrop_d  = (coinRise[0] & coinRise[1]) | (coinRise[0] & coinRise[2]) |
                  (coinRise[0] & coinRise[3]) | (coinRise[1] & coinRise[2]) |
                  (coinRise[1] & coinRise[3]) | (coinRise[2] & coinRise[3]);
    if (coinRise[3])      coinValue_d = VAL3;
    else if (coinRise[2]) coinValue_d = VAL2;
    else if (coinRise[1]) coinValue_d = VAL1;
    else if (coinRise[0]) coinValue_d = VAL0;
    else                  coinValue_d = 5'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      stable_q    <= '0;
      stableDly_q <= '0;
      for (int ch = 0; ch < NCH; ch++) cnt_q[ch] <= '0;
      L_pulse     <= 1'b0;
      R_pulse     <= 1'b0;
      C_pulse     <= 1'b0;
      coin_valid  <= 1'b0;
      coin_value  <= 5'd0;
      coin_drop   <= 1'b0;
    end else begin
      s1_q        <= rawIn;
      s2_q        <= s1_q;
      stable_q    <= stable_d;
      stableDly_q <= stable_q;
      for (int ch = 0; ch < NCH; ch++) cnt_q[ch] <= cnt_d[ch];
      L_pulse     <= rise[0];
      R_pulse     <= rise[1];
      C_pulse     <= rise[2];
      coin_valid  <= coinValid_d;
      coin_value  <= coinValue_d;
      coin_drop   <= coinDrop_d;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a 4-cycle debounce window; pulse timing
// and coin encoding are checked against hand-computed cycle positions.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       L_button, R_button, C_button;
  logic [3:0] switch;
  logic       L_pulse, R_pulse, C_pulse, coin_valid, coin_drop;
  logic [4:0] coin_value;

  int totalChecks = 0;
  int failCount   = 0;

  // Output vector layout: {L, R, C, coin_valid, coin_value[4:0], coin_drop}
  localparam logic [9:0] HIT_L   = 10'b1_0_0_0_00000_0;
  localparam logic [9:0] HIT_R   = 10'b0_1_0_0_00000_0;
  localparam logic [9:0] HIT_C   = 10'b0_0_1_0_00000_0;
  localparam logic [9:0] HIT_C10 = 10'b0_0_0_1_01010_0;
  localparam logic [9:0] HIT_C20 = 10'b0_0_0_1_10100_1;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .COIN0_VAL(1),
    .COIN1_VAL(5),
    .COIN2_VAL(10),
    .COIN3_VAL(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .L_button(L_button),
    .R_button(R_button),
    .C_button(C_button),
    .switch(switch),
    .L_pulse(L_pulse),
    .R_pulse(R_pulse),
    .C_pulse(C_pulse),
    .coin_valid(coin_valid),
    .coin_value(coin_value),
    .coin_drop(coin_drop)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outVec();
    return {L_pulse, R_pulse, C_pulse, coin_valid, coin_value, coin_drop};
  endfunction

  task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles with inputs held; only tick number hitAt (1-based) may show hit.
  task automatic applyStimulus(input string tag, input int n, input int hitAt, input logic [9:0] hit);
    for (int i = 1; i <= n; i++) begin
      tick();
      checkOutput($sformatf("%s[%0d]", tag, i), outVec(), (i == hitAt) ? hit : 10'd0);
    end
  endtask

  initial begin
    logic [3:0] bounce;
    rst = 1'b0; L_button = 0; R_button = 0; C_button = 0; switch = 4'd0;

    // 1. Reset with idle inputs
    applyStimulus("reset", 10, 0, 10'd0);
    rst = 1'b1;
    applyStimulus("idle", 3, 0, 10'd0);

    // 1b. Reset mid-count must clear the counter: a following 3-cycle press is too short
    R_button = 1;
    applyStimulus("rMidCount", 4, 0, 10'd0);
    rst = 1'b0; R_button = 0;
    applyStimulus("rReset", 1, 0, 10'd0);
    rst = 1'b1; R_button = 1;
    applyStimulus("rShort", 3, 0, 10'd0);
    R_button = 0;
    applyStimulus("rAfter", 12, 0, 10'd0);

    // 2. Clean L press
    L_button = 1;
    applyStimulus("lPress", 20, 7, HIT_L);
    L_button = 0;
    applyStimulus("lRelease", 10, 0, 10'd0);

    // 3. C bounce 1,0,1,0 then hold
    bounce = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      C_button = bounce[i];
      applyStimulus($sformatf("cBounce%0d", i), 1, 0, 10'd0);
    end
    C_button = 1;
    applyStimulus("cHold", 20, 7, HIT_C);
    C_button = 0;
    applyStimulus("cRelease", 10, 0, 10'd0);
    C_button = 1;
    applyStimulus("cGlitch", 3, 0, 10'd0);
    C_button = 0;
    applyStimulus("cGlitchAfter", 12, 0, 10'd0);

    // 4. Single coin
    switch = 4'b0100;
    applyStimulus("coin10", 30, 7, HIT_C10);
    switch = 4'b0000;
    applyStimulus("coin10Rel", 12, 0, 10'd0);

    // 5. Two coins at once: highest wins, drop flagged
    switch = 4'b1001;
    applyStimulus("coinDual", 15, 7, HIT_C20);
    switch = 4'b0000;
    applyStimulus("coinDualRel", 12, 0, 10'd0);

    // 6. L held through reset fires after release
    L_button = 1; rst = 1'b0;
    applyStimulus("lInReset", 5, 0, 10'd0);
    rst = 1'b1;
    applyStimulus("lAfterReset", 15, 7, HIT_L);
    L_button = 0;
    applyStimulus("lAfterRel", 10, 0, 10'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", totalChecks, failCount);
    $finish;
  end

endmodule
